// File: rtl/ntt_bfly_addsub_if.sv
// Butterfly add/sub bus: operand/control inputs toward the unit,
// results and stage status back out.
interface ntt_bfly_addsub_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] wb_in;
    logic [DATA_WIDTH-1:0] modular;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] x_out;
    logic [DATA_WIDTH-1:0] y_out;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_valid, a_in, wb_in, modular,
        input  out_valid, x_out, y_out, busy, done
    );

    modport slave (
        input  start, in_valid, a_in, wb_in, modular,
        output out_valid, x_out, y_out, busy, done
    );
endinterface

// File: rtl/ntt_bfly_addsub.sv
// Add/subtract half of a radix-2 NTT butterfly: X = A+WB mod q, Y = A-WB mod q.
// A is delayed MUL_LAT cycles to meet the multiplier result on wb_in.
// A stage FSM accepts BFLY_NUM operands and pulses done after the last result.
// Optional macro BFLY_OUT_REG_EN adds one output register stage.
module ntt_bfly_addsub #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_LAT    = 4,
    parameter int BFLY_NUM   = 512,
    parameter int CNT_W      = $clog2(BFLY_NUM + 1)
) (
    input logic               clk,
    input logic               rst,
    ntt_bfly_addsub_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BFLY_NUM - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] issue_cnt, issue_cnt_nxt;
    logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
    logic             done_q, done_nxt;
    logic             accept;
    logic             fin_vld;

    logic [MUL_LAT:1]                 vld_pipe;
    logic [MUL_LAT:1][DATA_WIDTH-1:0] a_pipe;

    logic [DATA_WIDTH-1:0] a_al, diff, x_c, y_c;
    logic [DATA_WIDTH:0]   sum, sum_sub;

    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_x, s1_y;

    // Stage control: operand acceptance, counters and done pulse
    always_comb begin
        state_nxt     = state;
        issue_cnt_nxt = issue_cnt;
        out_cnt_nxt   = out_cnt;
        done_nxt      = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                // a start coinciding with done is dropped
                if (bus.start && !done_q) begin
                    state_nxt     = RUN;
                    issue_cnt_nxt = '0;
                    out_cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    accept        = 1'b1;
                    issue_cnt_nxt = issue_cnt + 1'b1;
                    if (issue_cnt == LAST) state_nxt = DRAIN;
                end
                if (fin_vld) out_cnt_nxt = out_cnt + 1'b1;
            end
            DRAIN: begin
                if (fin_vld) begin
                    out_cnt_nxt = out_cnt + 1'b1;
                    if (out_cnt == LAST) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            out_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_cnt_nxt;
            out_cnt   <= out_cnt_nxt;
            done_q    <= done_nxt;
        end
    end

    // A delay line, free running; only accepted operands enter it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
        end else begin
            vld_pipe[1] <= accept;
            a_pipe[1]   <= accept ? bus.a_in : '0;
            for (int i = 2; i <= MUL_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
            end
        end
    end

    // Modular add/sub on the aligned A and W*B pair
    assign a_al    = a_pipe[MUL_LAT];
    assign sum     = {1'b0, a_al} + {1'b0, bus.wb_in};
    assign sum_sub = sum - {1'b0, bus.modular};
    assign x_c     = (sum >= {1'b0, bus.modular}) ? sum_sub[DATA_WIDTH-1:0]
                                                  : sum[DATA_WIDTH-1:0];
    assign diff    = a_al - bus.wb_in;
    assign y_c     = (a_al >= bus.wb_in) ? diff : diff + bus.modular;

    // Result register; data holds while no valid result arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_vld <= vld_pipe[MUL_LAT];
            if (vld_pipe[MUL_LAT]) begin
                s1_x <= x_c;
                s1_y <= y_c;
            end
        end
    end

`ifdef BFLY_OUT_REG_EN
    logic                  s2_vld;
    logic [DATA_WIDTH-1:0] s2_x, s2_y;

    // Extra output stage for timing; done follows this valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_x   <= '0;
            s2_y   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_x <= s1_x;
                s2_y <= s1_y;
            end
        end
    end

    assign fin_vld   = s2_vld;
    assign bus.x_out = s2_x;
    assign bus.y_out = s2_y;
`else
    assign fin_vld   = s1_vld;
    assign bus.x_out = s1_x;
    assign bus.y_out = s1_y;
`endif

    assign bus.out_valid = fin_vld;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ntt_bfly_addsub.sv
// Scoreboard bench for ntt_bfly_addsub: q=12289, MUL_LAT=4, BFLY_NUM=4.
module tb_ntt_bfly_addsub;
    localparam int DW      = 32;
    localparam int MUL_LAT = 4;
    localparam int BFLY    = 4;
`ifdef BFLY_OUT_REG_EN
    localparam int LAT = MUL_LAT + 2;
`else
    localparam int LAT = MUL_LAT + 1;
`endif

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] wb_src;
    logic [DW-1:0] wb_d [MUL_LAT];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    int            last_out_cyc = -100;
    exp_t          sb[$];

    ntt_bfly_addsub_if #(.DATA_WIDTH(DW)) bus();

    ntt_bfly_addsub #(
        .DATA_WIDTH(DW),
        .MUL_LAT   (MUL_LAT),
        .BFLY_NUM  (BFLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the multiplier: wb_src reappears on wb_in MUL_LAT cycles later
    always @(posedge clk) begin
        wb_d[0] <= wb_src;
        for (int i = 1; i < MUL_LAT; i++) wb_d[i] <= wb_d[i-1];
    end
    assign bus.wb_in = wb_d[MUL_LAT-1];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One cycle of in_valid; push the expected result when the operand should be accepted
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] wb, input bit push,
                         input logic [DW-1:0] x, input logic [DW-1:0] y);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        wb_src       = wb;
        if (push) begin
            e.x = x; e.y = y; e.cyc = cyc + LAT;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        wb_src       = '0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n0 = done_cnt;
        int k = 0;
        while (done_cnt == n0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (done_cnt == n0) begin
            bad++;
            $display("FAIL %s: done not seen within 60 cycles (dones=%0d, required %0d)", name, done_cnt, n0 + 1);
        end
    endtask

    // Monitor: pops the scoreboard on every result, checks done placement
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: cyc=%0d x=%0d y=%0d, required no out_valid", cyc, bus.x_out, bus.y_out);
                end else begin
                    e = sb.pop_front();
                    if (bus.x_out !== e.x || bus.y_out !== e.y || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL result: got x=%0d y=%0d cyc=%0d, required x=%0d y=%0d cyc=%0d",
                                 bus.x_out, bus.y_out, cyc, e.x, e.y, e.cyc);
                    end
                end
                last_out_cyc = cyc;
            end
            if (bus.done) begin
                total++;
                if (cyc != last_out_cyc + 1 || bus.busy !== 1'b0 || sb.size() != 0) begin
                    bad++;
                    $display("FAIL done: cyc=%0d busy=%0b pending=%0d, required cyc=%0d busy=0 pending=0",
                             cyc, bus.busy, sb.size(), last_out_cyc + 1);
                end
                done_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.modular  = 32'd12289;
        wb_src       = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_x", bus.x_out, 0);
        chk("rst_y", bus.y_out, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // in_valid in IDLE must be ignored
        issue(123, 45, 0, 0, 0);
        issue(7, 7, 0, 0, 0);
        repeat (8) @(negedge clk);

        // Stage 1: isolated first vector, then boundary values
        pulse_start();
        chk("busy_run", {31'd0, bus.busy}, 1);
        issue(5, 12288, 1, 4, 6);
        repeat (8) @(negedge clk);
        issue(12288, 12288, 1, 12287, 0);
        issue(0, 0, 1, 0, 0);
        issue(1, 10, 1, 11, 12280);
        wait_done("stage1_done");
        repeat (4) @(negedge clk);

        // Stage 2: start with a coincident in_valid (dropped), then 4 back-to-back
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.a_in     = 999;
        wb_src       = 1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        wb_src       = '0;
        for (int i = 1; i <= 4; i++)
            issue(i, 10, 1, 10 + i, 12279 + i);
        issue(50, 50, 0, 0, 0);          // DRAIN: ignored
        pulse_start();                    // DRAIN: ignored
        wait_done("stage2_done");
        repeat (10) @(negedge clk);
        chk("stage2_one_done", done_cnt, 2);

        // Stage 3: reset with two operands in flight
        pulse_start();
        issue(7, 3, 1, 10, 4);
        issue(100, 200, 1, 300, 12189);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("midrst_x", bus.x_out, 0);
        chk("midrst_y", bus.y_out, 0);
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        chk("midrst_done", {31'd0, bus.done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", done_cnt, 2);

        // Stage 4: full stage after reset, sums landing exactly on q
        pulse_start();
        issue(6000, 6289, 1, 0, 12000);
        issue(12288, 1, 1, 0, 12287);
        issue(3, 3, 1, 6, 0);
        issue(9, 12280, 1, 0, 18);
        wait_done("stage4_done");
        repeat (10) @(negedge clk);

        chk("final_done_count", done_cnt, 3);
        chk("final_pending", sb.size(), 0);
        chk("final_busy", {31'd0, bus.busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ntt_bfly_addsub.md
Name: ntt_bfly_addsub

Overview:
- Modular add/subtract back half of the NTT/FFT radix-2 Cooley-Tukey butterfly.
- Sits directly downstream of the modular multiplier (Barrett multiplier), consuming its W*B mod q result.
- Delays operand A internally to align with the multiplier latency, then produces X = A+WB mod q and Y = A-WB mod q.
- Includes a per-stage butterfly counter and a start/busy/done control FSM.

Parameters:
DATA_WIDTH, 32, operand/modulus width; equals the codebase DATA_WIDTH define
MUL_LAT, 4, cycles from the multiplier operand inputs to its registered result; valid range 1..16
BFLY_NUM, 512, butterflies per NTT stage; must be >= 1
CNT_W, $clog2(BFLY_NUM+1), counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse, begins a stage
in_valid  input  1  A operand valid; the same cycle B and W enter the multiplier
a_in  input  DATA_WIDTH  butterfly top operand A, < modular
wb_in  input  DATA_WIDTH  multiplier result W*B mod q, arrives MUL_LAT cycles after in_valid
modular  input  DATA_WIDTH  prime q, held stable while busy
out_valid  output  1  x_out/y_out valid
x_out  output  DATA_WIDTH  (A + WB) mod q
y_out  output  DATA_WIDTH  (A - WB) mod q
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse after the last butterfly output of a stage

Behaviour:
- Reset: async assertion clears everything immediately.
  - out_valid=0, x_out=0, y_out=0, busy=0, done=0.
  - FSM=IDLE, counters=0, delay-line data and valid bits=0.
- Reset mid-stage: all in-flight butterflies are discarded. No out_valid and no done until a new start.
- Delay line: MUL_LAT-deep shift register of {valid, A}, advancing every cycle (no stall).
  - A is captured only when in_valid=1 and the FSM accepts it.
  - The tap at depth MUL_LAT pairs with wb_in in the same cycle.
- Arithmetic, combinational on the aligned pair, then registered:
  - sum = A + WB in DATA_WIDTH+1 bits; x = (sum >= q) ? sum-q : sum.
  - diff = A - WB; y = (A >= WB) ? diff : diff+q, truncated to DATA_WIDTH.
  - Inputs are required < q. Results for out-of-range inputs are don't-care but must not hang the FSM.
- Latency: out_valid and results appear MUL_LAT+1 cycles after the accepted in_valid.
  - Throughput is 1 butterfly per cycle.
  - x_out/y_out hold their last value while out_valid=0.
- FSM states:
  - IDLE: busy=0. in_valid is ignored: not captured, no output. start -> RUN; issue_cnt=0, out_cnt=0.
  - RUN: each in_valid increments issue_cnt. The cycle issue_cnt reaches BFLY_NUM -> DRAIN.
  - DRAIN: in_valid is ignored. Each out_valid increments out_cnt (out_cnt also counts in RUN). When out_cnt reaches BFLY_NUM, pulse done for one cycle -> IDLE.
- start while busy: ignored.
- start in the same cycle as done: ignored. A new start is accepted from the cycle after done.
- Simultaneous start and in_valid in IDLE: that in_valid is ignored. The first accepted operand is in the cycle after start.
- BFLY_NUM=1: RUN lasts one accepted operand, then DRAIN.
- done and the final out_valid: done is asserted the cycle after the final out_valid. busy falls with done.

Optional Feature:
- Macro: BFLY_OUT_REG_EN.
- When defined:
  - An extra output register stage is added on out_valid/x_out/y_out for timing closure.
  - Latency becomes MUL_LAT+2.
  - out_cnt counts at the final registered out_valid, so done is delayed one cycle accordingly.
  - The extra stage resets to 0.
- When undefined: latency is MUL_LAT+1, with no extra flops.

Test Plan:
- q=12289, MUL_LAT=4: start, then in_valid with A=5; drive wb_in=12288 4 cycles later -> 5 cycles after in_valid: out_valid=1, x_out=4, y_out=6.
- q=12289: A=12288, WB=12288 -> x_out=12287, y_out=0. A=0, WB=0 -> x_out=0, y_out=0.
- BFLY_NUM=4: 4 back-to-back in_valid after start, with A=1..4 and WB=10 -> 4 consecutive outputs x=11..14, y=12280..12283. done pulses exactly one cycle after the 4th out_valid, and busy drops with it.
- in_valid pulses in IDLE, plus a 5th in_valid in DRAIN (BFLY_NUM=4) -> no extra out_valid. A start during DRAIN is ignored, and done still occurs once.
- Assert rst 2 cycles after the 2nd accepted operand of a BFLY_NUM=4 stage -> all outputs 0 immediately with no subsequent out_valid/done. A new start then completes a full 4-butterfly stage normally.
- With BFLY_OUT_REG_EN defined, repeat the first case -> result appears 6 cycles after in_valid with identical values, and done shifts by one cycle.
